bmem_line_adapter: RTL

Line adapter and arbiter between the CPU's instruction cache, data cache, and the banked memory port (`bmem_*`). It serves one outstanding 256-bit line transaction at a time. Each line moves as a 4-beat, 64-bit burst. Reads return on the `bmem_r*` channel, and the adapter reassembles the beats into a full line for the requesting cache. The `bmem_*` ports of `cpu` connect directly to this block.

---
 rtl/bmem_line_adapter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bmem_line_adapter.sv
// Arbitrates icache/dcache line requests onto the banked memory port, one 256-bit
// line at a time as a 4-beat burst, and reassembles read beats into full lines.
module bmem_line_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic [ADDR_W-1:0]       i_addr,
    output logic [BEAT_W*BEATS-1:0] i_rdata,
    output logic                    i_resp,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_W-1:0]       d_addr,
    input  logic [BEAT_W*BEATS-1:0] d_wdata,
    output logic [BEAT_W*BEATS-1:0] d_rdata,
    output logic                    d_resp,
    output logic [ADDR_W-1:0]       bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [ADDR_W-1:0]       bmem_raddr,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF_W  = $clog2(BEAT_W / 8 * BEATS);
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, RESP} state_t;
    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic              last_d, last_d_nxt;   // 1 = dcache won the most recent grant
    logic              gnt_d, gnt_d_nxt;
    line_t             wbuf, line_buf, line_asm;
    logic              pick_d, load_wbuf, beat_hit;
    logic [ADDR_W-1:0] addr_nxt;
    logic              read_nxt, write_nxt, i_resp_nxt, d_resp_nxt;
    logic [BEAT_W-1:0] wdata_nxt;
    logic [LINE_W-1:0] i_rdata_nxt, d_rdata_nxt;

    assign cnt_inc  = cnt + 1'b1;
    assign pick_d   = d_req && (!i_req || !last_d);
    assign beat_hit = (state == RD_DATA) && bmem_rvalid && (bmem_raddr == bmem_addr);

    always_comb begin
        line_asm      = line_buf;
        line_asm[cnt] = bmem_rdata;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_d_nxt  = last_d;
        gnt_d_nxt   = gnt_d;
        addr_nxt    = bmem_addr;
        read_nxt    = 1'b0;
        write_nxt   = 1'b0;
        wdata_nxt   = bmem_wdata;
        i_resp_nxt  = 1'b0;
        d_resp_nxt  = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        load_wbuf   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_d_nxt  = pick_d;
                    last_d_nxt = pick_d;
                    cnt_nxt    = '0;
                    addr_nxt   = (pick_d ? d_addr : i_addr) & LINE_MASK;
                    if (pick_d && d_we) begin
                        state_nxt = WR_BURST;
                        write_nxt = 1'b1;
                        wdata_nxt = d_wdata[BEAT_W-1:0];
                        load_wbuf = 1'b1;
                    end else begin
                        state_nxt = RD_CMD;
                        read_nxt  = 1'b1;
                    end
                end
            end
            RD_CMD: begin
                read_nxt = !bmem_ready;
                if (bmem_ready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (beat_hit) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == LAST_BEAT) begin
                        state_nxt  = RESP;
                        i_resp_nxt = !gnt_d;
                        d_resp_nxt = gnt_d;
                        if (gnt_d) d_rdata_nxt = line_asm;
                        else       i_rdata_nxt = line_asm;
                    end
                end
            end
            WR_BURST: begin
                write_nxt = 1'b1;
                if (bmem_ready) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == LAST_BEAT) begin
                        state_nxt  = RESP;
                        write_nxt  = 1'b0;
                        d_resp_nxt = 1'b1;
                    end else begin
                        wdata_nxt = wbuf[cnt_inc];
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_d     <= 1'b0;
            gnt_d      <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_d     <= last_d_nxt;
            gnt_d      <= gnt_d_nxt;
            bmem_addr  <= addr_nxt;
            bmem_read  <= read_nxt;
            bmem_write <= write_nxt;
            bmem_wdata <= wdata_nxt;
            i_resp     <= i_resp_nxt;
            d_resp     <= d_resp_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

    // NOTE: the line buffers are data-only storage, always written before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load_wbuf) wbuf <= d_wdata;
        if (beat_hit)  line_buf[cnt] <= bmem_rdata;
    end

endmodule
